// File: rtl/player_input_if.sv
// Button/status bundle between the player input decoder and the game logic.
// The decoder takes the slave view; the game core or a bench takes the master view.
interface player_input_if;
    logic       i_Hit;
    logic       i_Stay;
    logic [4:0] i_StateFSM;
    logic       o_HitPulse;
    logic       o_StayPulse;
    logic       o_Busy;

    modport master (
        output i_Hit,
        output i_Stay,
        output i_StateFSM,
        input  o_HitPulse,
        input  o_StayPulse,
        input  o_Busy
    );

    modport slave (
        input  i_Hit,
        input  i_Stay,
        input  i_StateFSM,
        output o_HitPulse,
        output o_StayPulse,
        output o_Busy
    );
endinterface

// File: rtl/player_input_decoder.sv
// Debounces the active-low Hit/Stay buttons and emits one strobe per accepted press.
// Define PLAYER_INPUT_SYNC_EN to add a two-flop synchronizer on each button.
module player_input_decoder #(
    parameter logic [7:0] DEBOUNCE_CYCLES = 8'd16,
    parameter logic [4:0] PLAYER_TURN     = 5'b01001
) (
    input logic           clk,
    input logic           Reset_n,
    player_input_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_HIT,
        DEB_STAY,
        CONFLICT,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] LAST_COUNT = DEBOUNCE_CYCLES - 8'd1;

    logic   hit_s;
    logic   stay_s;
    state_t state;
    state_t state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic   hit_pulse;
    logic   stay_pulse;
    logic   hit_pulse_next;
    logic   stay_pulse_next;
    logic   busy;

`ifdef PLAYER_INPUT_SYNC_EN
    logic [1:0] hit_sync;
    logic [1:0] stay_sync;

    // Reset to the released level so no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            hit_sync  <= 2'b11;
            stay_sync <= 2'b11;
        end else begin
            hit_sync  <= {hit_sync[0], bus.i_Hit};
            stay_sync <= {stay_sync[0], bus.i_Stay};
        end
    end

    assign hit_s  = hit_sync[1];
    assign stay_s = stay_sync[1];
`else
    assign hit_s  = bus.i_Hit;
    assign stay_s = bus.i_Stay;
`endif

    // Reset parks in WAIT_RELEASE so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state      <= WAIT_RELEASE;
            cnt        <= 8'd0;
            hit_pulse  <= 1'b0;
            stay_pulse <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            hit_pulse  <= hit_pulse_next;
            stay_pulse <= stay_pulse_next;
            busy       <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        hit_pulse_next  = 1'b0;
        stay_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (!hit_s && stay_s) begin
                    state_next = DEB_HIT;
                    cnt_next   = 8'd0;
                end else if (hit_s && !stay_s) begin
                    state_next = DEB_STAY;
                    cnt_next   = 8'd0;
                end else if (!hit_s && !stay_s) begin
                    state_next = CONFLICT;
                end
            end
            DEB_HIT: begin
                if (hit_s) begin
                    state_next = IDLE;
                end else if (!stay_s) begin
                    state_next = CONFLICT;
                end else if (cnt >= LAST_COUNT) begin
                    // The press is consumed even when it is not the player's turn.
                    state_next     = WAIT_RELEASE;
                    hit_pulse_next = (bus.i_StateFSM == PLAYER_TURN);
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DEB_STAY: begin
                if (stay_s) begin
                    state_next = IDLE;
                end else if (!hit_s) begin
                    state_next = CONFLICT;
                end else if (cnt >= LAST_COUNT) begin
                    state_next      = WAIT_RELEASE;
                    stay_pulse_next = (bus.i_StateFSM == PLAYER_TURN);
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            CONFLICT, WAIT_RELEASE: begin
                if (hit_s && stay_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = WAIT_RELEASE;
            end
        endcase
    end

    assign bus.o_HitPulse  = hit_pulse;
    assign bus.o_StayPulse = stay_pulse;
    assign bus.o_Busy      = busy;

endmodule
